aib_ch_bringup_seq: RTL and testbench

- Sequences link bring-up across the 24 master-to-slave AIB channels of the EMIB interconnect.
- Walks the enabled logical channels one at a time. For each, it raises a calibration request on the mapped physical channel, then waits for that channel's done or a programmable timeout.
- Records per-channel pass/fail and signals completion.
- Sits on the master die between the configuration logic and the per-channel AIB adapters. It honours the same channel rotation the EMIB model applies.

---
 rtl/aib_ch_bringup_seq.sv | 135 +++++++++++++
 tb/tb_aib_ch_bringup_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_ch_bringup_seq.sv
// Link bring-up sequencer: walks enabled AIB channels in logical order, requests calibration
// on the mapped physical channel and records pass (done seen) or fail (timeout) per channel.
module aib_ch_bringup_seq #(
    parameter int NUM_CH    = 24,
    parameter int ROTATE    = 0,
    parameter int TIMEOUT_W = 16,
    parameter int SETTLE    = 4,
    localparam int CH_W     = $clog2(NUM_CH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NUM_CH-1:0]    i_ch_enable,
    input  logic [TIMEOUT_W-1:0] i_timeout,
    input  logic [NUM_CH-1:0]    i_ch_done,
    output logic [NUM_CH-1:0]    o_ch_req,
    output logic [NUM_CH-1:0]    o_ch_pass,
    output logic [NUM_CH-1:0]    o_ch_fail,
    output logic [CH_W-1:0]      o_cur_ch,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_state
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [CH_W-1:0]       idx, idx_next;
    logic [TIMEOUT_W-1:0]  timer, timer_next;
    logic [SW-1:0]         settle, settle_next;
    logic [NUM_CH-1:0]     pass, pass_next;
    logic [NUM_CH-1:0]     fail, fail_next;
    logic [CH_W-1:0]       phys;

    // Request/done live in the physical channel space; status stays logical.
    assign phys = (ROTATE != 0) ? (CH_W'(NUM_CH - 1) - idx) : idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            timer  <= '0;
            settle <= '0;
            pass   <= '0;
            fail   <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            timer  <= timer_next;
            settle <= settle_next;
            pass   <= pass_next;
            fail   <= fail_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        timer_next  = timer;
        settle_next = settle;
        pass_next   = pass;
        fail_next   = fail;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    pass_next  = '0;
                    fail_next  = '0;
                    idx_next   = '0;
                    state_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if (idx == CH_W'(NUM_CH)) begin
                    state_next = S_FINISH;
                end else if (!i_ch_enable[idx]) begin
                    idx_next = idx + CH_W'(1);
                end else begin
                    timer_next = i_timeout;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                // Done wins over a timeout expiring in the same cycle.
                if (i_ch_done[phys]) begin
                    pass_next[idx] = 1'b1;
                    settle_next    = '0;
                    state_next     = S_RELEASE;
                end else if (timer == '0) begin
                    fail_next[idx] = 1'b1;
                    settle_next    = '0;
                    state_next     = S_RELEASE;
                end else begin
                    timer_next = timer - TIMEOUT_W'(1);
                end
            end
            S_RELEASE: begin
                if (settle == SW'(SETTLE - 1)) begin
                    idx_next   = idx + CH_W'(1);
                    state_next = S_SELECT;
                end else begin
                    settle_next = settle + SW'(1);
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_ch_req = '0;
        if (state == S_REQ) begin
            o_ch_req[phys] = 1'b1;
        end
    end

    assign o_ch_pass = pass;
    assign o_ch_fail = fail;
    assign o_cur_ch  = idx;
    assign o_busy    = (state != S_IDLE);
    assign o_done    = (state == S_FINISH);
    assign o_state   = state;

endmodule

// File: tb/tb_aib_ch_bringup_seq.sv
// Directed bench for aib_ch_bringup_seq: one straight-mapped and one rotated instance,
// each driven by a small calibration-done responder model.
module tb_aib_ch_bringup_seq;

    localparam int NUM_CH = 24;
    localparam int CH_W   = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic              rot_start;
    logic [NUM_CH-1:0] ch_enable;
    logic [15:0]       timeout;

    logic [NUM_CH-1:0] ch_done, ch_req, ch_pass, ch_fail;
    logic [CH_W-1:0]   cur_ch;
    logic              busy, done;
    logic [2:0]        state;

    logic [NUM_CH-1:0] rot_ch_done, rot_ch_req, rot_ch_pass, rot_ch_fail;
    logic [CH_W-1:0]   rot_cur_ch;
    logic              rot_busy, rot_done;
    logic [2:0]        rot_state;

    // Responder model: done mirrors the request once it has been held for `delay` cycles.
    logic done_all;
    logic done_en;
    int   delay;
    int   req_cnt;
    int   rot_req_cnt;

    assign ch_done     = done_all ? '1 : ((done_en && req_cnt >= delay) ? ch_req : '0);
    assign rot_ch_done = done_all ? '1 : ((done_en && rot_req_cnt >= delay) ? rot_ch_req : '0);

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    int edge0 = 0;
    int done_cnt;
    int done_cyc;
    int hi_cnt[NUM_CH];
    int rot_hi_cnt[NUM_CH];
    logic [NUM_CH-1:0] obs_q[$];
    logic [NUM_CH-1:0] exp_q[$];

    aib_ch_bringup_seq #(.NUM_CH(NUM_CH), .ROTATE(0), .TIMEOUT_W(16), .SETTLE(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_ch_enable(ch_enable),
        .i_timeout(timeout), .i_ch_done(ch_done), .o_ch_req(ch_req),
        .o_ch_pass(ch_pass), .o_ch_fail(ch_fail), .o_cur_ch(cur_ch),
        .o_busy(busy), .o_done(done), .o_state(state)
    );

    aib_ch_bringup_seq #(.NUM_CH(NUM_CH), .ROTATE(1), .TIMEOUT_W(16), .SETTLE(4)) u_dut_rot (
        .i_clk(clk), .i_rst(rst), .i_start(rot_start), .i_ch_enable(ch_enable),
        .i_timeout(timeout), .i_ch_done(rot_ch_done), .o_ch_req(rot_ch_req),
        .o_ch_pass(rot_ch_pass), .o_ch_fail(rot_ch_fail), .o_cur_ch(rot_cur_ch),
        .o_busy(rot_busy), .o_done(rot_done), .o_state(rot_state)
    );

    // Clock / reset-independent bookkeeping
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_no <= cycle_no + 1;
        req_cnt     <= (ch_req != '0) ? req_cnt + 1 : 0;
        rot_req_cnt <= (rot_ch_req != '0) ? rot_req_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (ch_req != '0) obs_q.push_back(ch_req);
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_req[i]) hi_cnt[i]++;
            if (rot_ch_req[i]) rot_hi_cnt[i]++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cycle_no - edge0 + 1;
        end
    end

    task automatic clear_stats();
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            hi_cnt[i] = 0;
            rot_hi_cnt[i] = 0;
        end
        done_cnt = 0;
        done_cyc = -1;
    endtask

    function automatic int total_hi();
        int s = 0;
        for (int i = 0; i < NUM_CH; i++) s += hi_cnt[i];
        return s;
    endfunction

    // Start pulse sampled at "edge 0"; the negedge after it is cycle 1.
    task automatic start_main();
        @(negedge clk);
        start = 1'b1;
        edge0 = cycle_no + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_main_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ch_req !== '0 || ch_pass !== '0 || ch_fail !== '0) begin
            errors++;
            $display("FAIL reset_status: req=%h pass=%h fail=%h, required all 0", ch_req, ch_pass, ch_fail);
        end
        checks++;
        if (cur_ch !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cur_ch=%0d busy=%b done=%b, required 0/0/0", cur_ch, busy, done);
        end
        checks++;
        if (state !== 3'd0 || rot_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d rot_state=%0d, required 0", state, rot_state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_pass();
        int nerr = 0;
        clear_stats();
        done_all  = 1'b1;
        done_en   = 1'b0;
        ch_enable = '1;
        timeout   = 16'd5;
        for (int i = 0; i < NUM_CH; i++) exp_q.push_back(NUM_CH'(1) << i);
        start_main();
        wait_main_idle(400);
        checks++;
        if (done_cyc !== 146 || done_cnt !== 1) begin
            errors++;
            $display("FAIL all_pass_timing: done cycle=%0d count=%0d, required 146/1", done_cyc, done_cnt);
        end
        checks++;
        if (ch_pass !== 24'hFFFFFF || ch_fail !== 24'h0) begin
            errors++;
            $display("FAIL all_pass_status: pass=%h fail=%h, required ffffff/000000", ch_pass, ch_fail);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL all_pass_req_count: %0d request cycles, required %0d", obs_q.size(), exp_q.size());
        end else begin
            while (exp_q.size() > 0) begin
                logic [NUM_CH-1:0] e, o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e) nerr++;
            end
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL all_pass_req_order: %0d out-of-order request cycles, required 0", nerr);
        end
        checks++;
        if (cur_ch !== 5'd24) begin
            errors++;
            $display("FAIL cur_ch_hold: cur_ch=%0d in idle, required 24", cur_ch);
        end
    endtask

    task automatic test_rotate();
        int others = 0;
        int n = 0;
        clear_stats();
        done_all  = 1'b0;
        done_en   = 1'b1;
        delay     = 5;
        ch_enable = 24'h000001;
        timeout   = 16'd100;
        @(negedge clk);
        rot_start = 1'b1;
        @(negedge clk);
        rot_start = 1'b0;
        while (rot_busy && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < NUM_CH - 1; i++) others += rot_hi_cnt[i];
        checks++;
        if (rot_hi_cnt[23] !== 6 || others !== 0 || rot_busy !== 1'b0) begin
            errors++;
            $display("FAIL rotate_req: req[23] cycles=%0d other=%0d busy=%b, required 6/0/0", rot_hi_cnt[23], others, rot_busy);
        end
        checks++;
        if (rot_ch_pass !== 24'h000001 || rot_ch_fail !== 24'h0) begin
            errors++;
            $display("FAIL rotate_status: pass=%h fail=%h, required 000001/000000", rot_ch_pass, rot_ch_fail);
        end
    endtask

    task automatic test_timeout();
        clear_stats();
        done_all  = 1'b0;
        done_en   = 1'b0;
        ch_enable = 24'h000010;
        timeout   = 16'd3;
        start_main();
        wait_main_idle(400);
        checks++;
        if (hi_cnt[4] !== 4 || total_hi() !== 4) begin
            errors++;
            $display("FAIL timeout_req: req[4] cycles=%0d total=%0d, required 4/4", hi_cnt[4], total_hi());
        end
        checks++;
        if (ch_fail !== 24'h000010 || ch_pass !== 24'h0) begin
            errors++;
            $display("FAIL timeout_status: pass=%h fail=%h, required 000000/000010", ch_pass, ch_fail);
        end
        checks++;
        if (done_cyc !== 34) begin
            errors++;
            $display("FAIL timeout_timing: done cycle=%0d, required 34", done_cyc);
        end
    endtask

    task automatic test_collision();
        clear_stats();
        done_all  = 1'b0;
        done_en   = 1'b1;
        delay     = 2;
        ch_enable = 24'h000010;
        timeout   = 16'd2;
        start_main();
        wait_main_idle(400);
        checks++;
        if (ch_pass !== 24'h000010 || ch_fail !== 24'h0 || hi_cnt[4] !== 3) begin
            errors++;
            $display("FAIL collision_pass: pass=%h fail=%h req cycles=%0d, required 000010/000000/3", ch_pass, ch_fail, hi_cnt[4]);
        end
        clear_stats();
        delay = 3;
        start_main();
        wait_main_idle(400);
        checks++;
        if (ch_pass !== 24'h0 || ch_fail !== 24'h000010 || hi_cnt[4] !== 3) begin
            errors++;
            $display("FAIL collision_fail: pass=%h fail=%h req cycles=%0d, required 000000/000010/3", ch_pass, ch_fail, hi_cnt[4]);
        end
    endtask

    task automatic test_disabled_ignored_start();
        int n = 0;
        clear_stats();
        done_all  = 1'b1;
        done_en   = 1'b0;
        ch_enable = '0;
        timeout   = 16'd3;
        start_main();
        // Second pulse sampled at the edge ending cycle 10 while busy.
        while (cycle_no - edge0 + 1 < 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (done_cyc !== 26 || done_cnt !== 1) begin
            errors++;
            $display("FAIL all_disabled_done: done cycle=%0d count=%0d, required 26/1", done_cyc, done_cnt);
        end
        checks++;
        if (total_hi() !== 0 || ch_pass !== '0 || ch_fail !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL all_disabled_quiet: req cycles=%0d pass=%h fail=%h busy=%b, required 0/0/0/0", total_hi(), ch_pass, ch_fail, busy);
        end
        // A start held during the FINISH cycle must be ignored.
        clear_stats();
        start_main();
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL start_in_finish: busy=%b done count=%0d, required 0/1", busy, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_stats();
        done_all  = 1'b1;
        done_en   = 1'b0;
        ch_enable = '1;
        timeout   = 16'd5;
        start_main();
        while (!ch_req[7] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ch_req !== 24'h000080 || ch_pass !== 24'h00007F) begin
            errors++;
            $display("FAIL reset_mid_pre: req=%h pass=%h, required 000080/00007f", ch_req, ch_pass);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ch_req !== '0 || ch_pass !== '0 || ch_fail !== '0 || busy !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: req=%h pass=%h fail=%h busy=%b state=%0d, required 0", ch_req, ch_pass, ch_fail, busy, state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_stats();
        start_main();
        wait_main_idle(400);
        checks++;
        if (ch_pass !== 24'hFFFFFF || ch_fail !== '0 || done_cyc !== 146 || done_cnt !== 1) begin
            errors++;
            $display("FAIL reset_mid_restart: pass=%h fail=%h done cycle=%0d count=%0d, required ffffff/0/146/1", ch_pass, ch_fail, done_cyc, done_cnt);
        end
    endtask

    initial begin
        start     = 1'b0;
        rot_start = 1'b0;
        ch_enable = '0;
        timeout   = '0;
        done_all  = 1'b0;
        done_en   = 1'b0;
        delay     = 0;
        clear_stats();
        test_reset();
        test_all_pass();
        test_rotate();
        test_timeout();
        test_collision();
        test_disabled_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
